mhsa_dma: RTL and testbench



---
 rtl/mhsa_pkg.sv | 16 +
 rtl/mhsa_sync_fifo.sv | 55 +++++
 rtl/mhsa_dma.sv | 136 +++++++++++++
 tb/tb_mhsa_dma.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mhsa_pkg.sv
// Shared definitions for the MHSA job sequencer: FSM states and start CSR field positions.
package mhsa_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StFlush,
        StWr,
        StDone
    } state_e;

    localparam int unsigned START_GO_BIT  = 0;
    localparam int unsigned START_LEN_MSB = 31;
    localparam int unsigned START_LEN_LSB = 16;

endpackage

// File: rtl/mhsa_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally on rdata.
module mhsa_sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mhsa_dma.sv
// Job sequencer: streams N SRAM words into the core, writes N results back, then pulses done.
// Owns the shared SRAM port only while busy.
module mhsa_dma
    import mhsa_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       start,
    input  logic [31:0]       input_base,
    input  logic [31:0]       output_base,
    output logic              busy,
    output logic              done_pulse,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_read_en,
    output logic              sram_write_en,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] in_tdata,
    output logic              in_tvalid,
    input  logic              in_tready,
    input  logic [DATA_W-1:0] out_tdata,
    input  logic              out_tvalid,
    output logic              out_tready
);

    localparam int unsigned FIFO_DEPTH = RD_LAT + 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LEN_W      = START_LEN_MSB - START_LEN_LSB + 1;

    state_e            state_q;
    logic              start_go_q;
    logic [LEN_W-1:0]  len_q, rd_cnt_q, acc_cnt_q;
    logic [ADDR_W-1:0] in_base_q, out_base_q, wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic [RD_LAT:0]   rd_pipe_shift;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       occupancy;
    logic              fifo_empty, fifo_full, fifo_pop;
    logic              launch, rd_credit, out_fire;
    logic              unused_bits;

    assign unused_bits = ^{start[START_LEN_LSB-1:START_GO_BIT+1], fifo_full};

    assign launch = (state_q == StIdle) && start[START_GO_BIT] && !start_go_q;

    // The beat leaving the FIFO this cycle frees a slot, which keeps reads at one per cycle.
    assign occupancy = 32'(fifo_count) + 32'($countones(rd_pipe_q));
    assign rd_credit = occupancy < (32'(FIFO_DEPTH) + 32'(fifo_pop));

    assign sram_read_en  = (state_q == StRd) && rd_credit;
    assign sram_write_en = wr_en_q;
    assign sram_wdata    = wr_data_q;
    assign sram_addr     = sram_read_en ? in_base_q + ADDR_W'(rd_cnt_q) : wr_addr_q;
    assign rd_pipe_shift = {rd_pipe_q, sram_read_en};

    assign in_tvalid  = !fifo_empty;
    assign fifo_pop   = in_tvalid && in_tready;
    assign out_tready = (state_q == StWr) && (acc_cnt_q != len_q);
    assign out_fire   = out_tvalid && out_tready;
    assign busy       = (state_q != StIdle);
    assign done_pulse = (state_q == StDone);

    mhsa_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pipe_q[RD_LAT-1]),
        .wdata (sram_rdata),
        .pop   (fifo_pop),
        .rdata (in_tdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            start_go_q <= 1'b0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            acc_cnt_q  <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_pipe_q  <= '0;
        end else begin
            start_go_q <= start[START_GO_BIT];
            rd_pipe_q  <= rd_pipe_shift[RD_LAT-1:0];
            wr_en_q    <= out_fire;
            if (out_fire) begin
                wr_addr_q <= out_base_q + ADDR_W'(acc_cnt_q);
                wr_data_q <= out_tdata;
                acc_cnt_q <= acc_cnt_q + LEN_W'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        len_q      <= start[START_LEN_MSB:START_LEN_LSB];
                        in_base_q  <= ADDR_W'(input_base);
                        out_base_q <= ADDR_W'(output_base);
                        rd_cnt_q   <= '0;
                        acc_cnt_q  <= '0;
                        state_q    <= (start[START_LEN_MSB:START_LEN_LSB] == '0) ? StDone : StRd;
                    end
                end
                StRd: begin
                    if (sram_read_en) begin
                        rd_cnt_q <= rd_cnt_q + LEN_W'(1);
                        if (rd_cnt_q == len_q - LEN_W'(1)) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (rd_pipe_q == '0 && fifo_empty) state_q <= StWr;
                end
                StWr: begin
                    // All beats accepted and the strobe for the last one is out this cycle.
                    if (wr_en_q && acc_cnt_q == len_q) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mhsa_dma.sv
// Bench for mhsa_dma: SRAM and echoing-core models, scoreboard queues per job.
module tb_mhsa_dma;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       start, input_base, output_base;
    logic              busy, done_pulse, sram_read_en, sram_write_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_rdata, in_tdata, out_tdata;
    logic              in_tvalid, in_tready, out_tvalid, out_tready;

    always #5 clk = ~clk;

    mhsa_dma #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .input_base    (input_base),
        .output_base   (output_base),
        .busy          (busy),
        .done_pulse    (done_pulse),
        .sram_addr     (sram_addr),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata),
        .in_tdata      (in_tdata),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .out_tdata     (out_tdata),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] mem [logic [31:0]];
    logic [63:0] core_q [$];
    logic        rd_pend;
    logic [31:0] rd_pend_addr;
    bit          rand_ready;
    int          issued, popped, s_occ;
    logic        s_rd, s_wr, s_inv, s_in, s_out, s_busy, s_done;
    logic [31:0] s_addr;
    logic [63:0] s_wdata, s_in_data;

    // One clock: drive models at negedge, sample outputs 1 time unit later.
    task automatic step();
        @(negedge clk);
        cyc++;
        sram_rdata = (rd_pend && mem.exists(rd_pend_addr)) ? mem[rd_pend_addr] : '0;
        in_tready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        out_tvalid = (core_q.size() > 0);
        out_tdata  = out_tvalid ? core_q[0] : '0;
        #1;
        s_rd      = sram_read_en;
        s_wr      = sram_write_en;
        s_addr    = sram_addr;
        s_wdata   = sram_wdata;
        s_inv     = in_tvalid;
        s_in      = in_tvalid && in_tready;
        s_in_data = in_tdata;
        s_out     = out_tvalid && out_tready;
        s_busy    = busy;
        s_done    = done_pulse;
        s_occ     = issued - popped;
        if (s_rd) issued++;
        if (s_in) popped++;
        rd_pend      = s_rd;
        rd_pend_addr = s_addr;
        if (s_out) void'(core_q.pop_front());
        if (s_in) core_q.push_back(s_in_data);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = '0; input_base = '0; output_base = '0;
        in_tready = 1'b0; out_tvalid = 1'b0; out_tdata = '0; sram_rdata = '0;
        rd_pend = 1'b0; rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, done_pulse, sram_read_en, sram_write_en, in_tvalid, out_tready} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {busy, done_pulse, sram_read_en, sram_write_en, in_tvalid, out_tready});
        end
        n_checks++;
        if (sram_addr !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h, expected 0", sram_addr);
        end
        n_checks++;
        if (sram_wdata !== '0) begin
            n_fail++; $display("FAIL reset_wdata: got %h, expected 0", sram_wdata);
        end
        n_checks++;
        if (in_tdata !== '0) begin
            n_fail++; $display("FAIL reset_tdata: got %h, expected 0", in_tdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_job(input string name, input int n, input logic [31:0] ib,
                            input logic [31:0] ob, input bit rnd, input bit toggle);
        logic [31:0] exp_ra[$], exp_wa[$];
        logic [63:0] exp_in[$], exp_wd[$];
        int          hs_q[$];
        logic [31:0] ea;
        logic [63:0] ed;
        int launch_cyc, lat, first_rd = -1, last_rd = -1, first_inv = -1, last_wr = -1;
        int done_cyc = -1, dones = 0, max_occ = 0, overlap = 0;
        start = '0; rand_ready = rnd; core_q.delete();
        step();
        issued = 0; popped = 0;
        for (int i = 0; i < n; i++) begin
            ed = {$urandom, $urandom};
            mem[ib + 32'(i)] = ed;
            exp_ra.push_back(ib + 32'(i));
            exp_in.push_back(ed);
            exp_wa.push_back(ob + 32'(i));
            exp_wd.push_back(ed);
        end
        input_base = ib; output_base = ob; start = {16'(n), 15'd0, 1'b1};
        launch_cyc = cyc;
        for (int t = 0; t < 300; t++) begin
            step();
            if (toggle && t < 8) begin
                start[0] = t[0]; input_base = 32'hDEAD_0000; output_base = 32'hBEEF_0000;
            end
            if (s_occ > max_occ) max_occ = s_occ;
            if (s_rd && s_wr) overlap++;
            if (s_inv && first_inv < 0) first_inv = cyc;
            if (s_rd) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                ea = exp_ra.size() > 0 ? exp_ra.pop_front() : 32'hXXXX_XXXX;
                n_checks++;
                if (s_addr !== ea) begin
                    n_fail++; $display("FAIL %s rd_addr: got %h, expected %h", name, s_addr, ea);
                end
            end
            if (s_in) begin
                ed = exp_in.size() > 0 ? exp_in.pop_front() : 64'hX;
                n_checks++;
                if (s_in_data !== ed) begin
                    n_fail++; $display("FAIL %s in_tdata: got %h, expected %h", name, s_in_data, ed);
                end
            end
            if (s_out) hs_q.push_back(cyc);
            if (s_wr) begin
                last_wr = cyc;
                ea  = exp_wa.size() > 0 ? exp_wa.pop_front() : 32'hXXXX_XXXX;
                ed  = exp_wd.size() > 0 ? exp_wd.pop_front() : 64'hX;
                lat = hs_q.size() > 0 ? cyc - hs_q.pop_front() : -1;
                n_checks++;
                if (s_addr !== ea || s_wdata !== ed || lat != 1) begin
                    n_fail++;
                    $display("FAIL %s write: got addr %h data %h lat %0d, expected %h %h 1",
                             name, s_addr, s_wdata, lat, ea, ed);
                end
            end
            if (s_done) begin
                dones++; done_cyc = cyc;
                n_checks++;
                if (last_wr + 1 != cyc || s_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got cycle %0d busy %b, expected %0d busy 1",
                             name, cyc, s_busy, last_wr + 1);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) break;
        end
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++; $display("FAIL %s timeout: got no done_pulse, expected one", name);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++; $display("FAIL %s done_count: got %0d, expected 1", name, dones);
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s busy_after_done: got %b, expected 0", name, s_busy);
        end
        n_checks++;
        if (exp_ra.size() + exp_in.size() + exp_wa.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing: got %0d/%0d/%0d left, expected 0", name,
                     exp_ra.size(), exp_in.size(), exp_wa.size());
        end
        n_checks++;
        if (max_occ > 2 || overlap != 0) begin
            n_fail++;
            $display("FAIL %s occupancy: got max %0d overlap %0d, expected <=2 and 0",
                     name, max_occ, overlap);
        end
        if (!rnd && !toggle) begin
            n_checks++;
            if (first_rd != launch_cyc + 1 || last_rd - first_rd != n - 1
                || first_inv - first_rd != 2) begin
                n_fail++;
                $display("FAIL %s rd_timing: got first %0d span %0d valid_lag %0d, expected %0d %0d 2",
                         name, first_rd, last_rd - first_rd, first_inv - first_rd,
                         launch_cyc + 1, n - 1);
            end
        end
    endtask

    task automatic test_zero_len();
        int viol = 0;
        start = '0; rand_ready = 1'b0; core_q.delete();
        step();
        input_base = 32'h700; output_base = 32'h800; start = 32'h0000_0001;
        step();
        n_checks++;
        if ({s_busy, s_done, s_rd, s_wr} !== 4'b1100) begin
            n_fail++;
            $display("FAIL zero_len_done: got %b, expected 1100", {s_busy, s_done, s_rd, s_wr});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_busy || s_done || s_rd || s_wr) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL zero_len_idle: got %0d active cycles, expected 0", viol);
        end
    endtask

    task automatic test_start_busy();
        int viol = 0;
        test_job("busy_toggle", 4, 32'h100, 32'h300, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_busy || s_rd || s_wr) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL held_start_relaunch: got %0d busy cycles, expected 0", viol);
        end
        test_job("relaunch", 4, 32'h180, 32'h380, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int reads = 0;
        int viol  = 0;
        start = '0; rand_ready = 1'b0; core_q.delete();
        step();
        for (int i = 0; i < 8; i++) mem[32'h40 + 32'(i)] = {$urandom, $urandom};
        input_base = 32'h40; output_base = 32'h600; start = {16'd8, 15'd0, 1'b1};
        for (int t = 0; t < 20 && reads < 2; t++) begin
            step();
            if (s_rd) reads++;
        end
        n_checks++;
        if (reads != 2) begin
            n_fail++; $display("FAIL reset_mid_reads: got %0d reads, expected 2", reads);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done_pulse, sram_read_en, sram_write_en, in_tvalid, out_tready} !== 6'b0
            || sram_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b addr %h, expected 000000 addr 0",
                     {busy, done_pulse, sram_read_en, sram_write_en, in_tvalid, out_tready},
                     sram_addr);
        end
        start = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_busy || s_rd || s_wr) viol++;
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles, expected 0", viol);
        end
        core_q.delete();
    endtask

    initial begin
        test_reset();
        test_job("nominal", 4, 32'h10, 32'h2000, 1'b0, 1'b0);
        test_job("backpressure", 8, 32'h80, 32'h1000, 1'b1, 1'b0);
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        test_job("addr_wrap", 4, 32'h500, 32'hFFFF_FFFE, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
